integ_sched: RTL and testbench

INTEG_SCHED -- requirements
Module: integ_sched

---
 rtl/integ_sched_pkg.sv | 18 +
 rtl/integ_sched_if.sv | 29 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/integ_sched.sv | 130 +++++++++++++
 tb/tb_integ_sched.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/integ_sched_pkg.sv
// Shared definitions for the integrating scheduler: FSM encoding and accumulator geometry.
package integ_sched_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StAdd  = 2'd2
   } state_e;

   // Accumulator is 33 bits: a 16-bit integer field on top of 17 fractional bits.
   localparam int unsigned AccW  = 33;
   localparam int unsigned FracW = 17;
   localparam int unsigned IntW  = AccW - FracW;

   localparam int unsigned DefNch = 4;
   localparam int unsigned DefIw  = 16;

endpackage

// File: rtl/integ_sched_if.sv
// Requester-side bundle of the integrating scheduler: add handshake, clears and readback.
interface integ_sched_if
   import integ_sched_pkg::*;
#(
   parameter int unsigned NCH = DefNch,
   parameter int unsigned IW  = DefIw,
   parameter int unsigned SW  = (NCH > 1) ? $clog2(NCH) : 1
) ();

   logic [NCH-1:0]    req;
   logic [NCH*IW-1:0] inc;
   logic [NCH-1:0]    clr;
   logic [NCH-1:0]    ack;
   logic [SW-1:0]     rd_sel;
   logic [AccW-1:0]   acc_out;
   logic [NCH-1:0]    ovf;
   logic              busy;

   modport master (
      output req, inc, clr, rd_sel,
      input  ack, acc_out, ovf, busy
   );

   modport slave (
      input  req, inc, clr, rd_sel,
      output ack, acc_out, ovf, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
   parameter int unsigned NCH = 4,
   parameter int unsigned SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] req,
   input  logic [SW-1:0]  ptr,
   output logic [NCH-1:0] grant,
   output logic [SW-1:0]  idx,
   output logic           valid
);

   // Scan offsets from farthest to nearest so the nearest requester to ptr wins.
   always_comb begin
      int c;
      logic [SW-1:0] sel;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      c     = 0;
      sel   = '0;
      for (int off = int'(NCH) - 1; off >= 0; off--) begin
         c   = (int'(ptr) + off) % int'(NCH);
         sel = SW'(c);
         if (req[sel]) begin
            grant      = '0;
            grant[sel] = 1'b1;
            idx        = sel;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/integ_sched.sv
// Integrating scheduler: NCH accumulators share one 16-bit adder, granted round-robin.
module integ_sched
   import integ_sched_pkg::*;
#(
   parameter int unsigned NCH = DefNch,
   parameter int unsigned IW  = DefIw
) (
   input  logic         clk,
   input  logic         rst_n,
   integ_sched_if.slave bus
);

   localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

   state_e                     state_q, state_d;
   logic [SW-1:0]              ptr_q, ptr_d;
   logic [SW-1:0]              win_idx_q, win_idx_d;
   logic [NCH-1:0]             win_oh_q, win_oh_d;
   logic [IntW-1:0]            op_acc_q, op_acc_d;
   logic [IntW-1:0]            op_inc_q, op_inc_d;
   logic [NCH-1:0][AccW-1:0]   acc_q, acc_d;
   logic [NCH-1:0]             ovf_q, ovf_d;
   logic [NCH-1:0]             ack_q, ack_d;
   logic [AccW-1:0]            acc_out_q, acc_out_d;

   logic [NCH-1:0]             grant;
   logic [SW-1:0]              grant_idx;
   logic                       grant_valid;
   logic [IntW:0]              sum;

   rr_arbiter #(
      .NCH (NCH),
      .SW  (SW)
   ) u_arb (
      .req   (bus.req),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (grant_idx),
      .valid (grant_valid)
   );

   // The single shared adder; bit IntW is the carry out of accumulator bit 32.
   assign sum = {1'b0, op_acc_q} + {1'b0, op_inc_q};

   // Next-state: arbitration, operand load, write-back, then clears override write-back.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_idx_d = win_idx_q;
      win_oh_d  = win_oh_q;
      op_acc_d  = op_acc_q;
      op_inc_d  = op_inc_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      ack_d     = '0;

      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               win_idx_d = grant_idx;
               win_oh_d  = grant;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            op_inc_d = IntW'(bus.inc[win_idx_q*IW +: IW]);
            op_acc_d = acc_q[win_idx_q][AccW-1:FracW];
            state_d  = StAdd;
         end
         StAdd: begin
            for (int unsigned i = 0; i < NCH; i++) begin
               if (win_oh_q[i]) begin
                  acc_d[i][AccW-1:FracW] = sum[IntW-1:0];
                  if (sum[IntW]) begin
                     ovf_d[i] = 1'b1;
                  end
               end
            end
            ack_d   = win_oh_q;
            ptr_d   = (win_idx_q == SW'(NCH - 1)) ? '0 : win_idx_q + SW'(1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Clear wins over a same-edge write-back; the ack above is left intact.
      for (int unsigned i = 0; i < NCH; i++) begin
         if (bus.clr[i]) begin
            acc_d[i] = '0;
            ovf_d[i] = 1'b0;
         end
      end

      // Read from next-state so a write-back on this edge is visible immediately after it.
      acc_out_d = acc_d[bus.rd_sel];
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         win_idx_q <= '0;
         win_oh_q  <= '0;
         op_acc_q  <= '0;
         op_inc_q  <= '0;
         acc_q     <= '0;
         ovf_q     <= '0;
         ack_q     <= '0;
         acc_out_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_idx_q <= win_idx_d;
         win_oh_q  <= win_oh_d;
         op_acc_q  <= op_acc_d;
         op_inc_q  <= op_inc_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         ack_q     <= ack_d;
         acc_out_q <= acc_out_d;
      end
   end

   assign bus.ack     = ack_q;
   assign bus.ovf     = ovf_q;
   assign bus.acc_out = acc_out_q;
   assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_integ_sched.sv
// Directed, table-driven bench for integ_sched with hand-written multi-cycle sequences.
module tb_integ_sched;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   integ_sched_if #(.NCH(4), .IW(16)) bus ();

   integ_sched #(
      .NCH (4),
      .IW  (16)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          ch;
      logic [15:0] inc;
      logic [32:0] exp_acc;
      logic [3:0]  exp_ovf;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raise req for one channel and count edges until an ack appears (bounded).
   task automatic do_add(input int ch, input logic [15:0] v, output int lat,
                         output logic [3:0] ack_seen);
      bus.inc[ch*16 +: 16] = v;
      bus.req[ch] = 1'b1;
      lat = 0;
      ack_seen = '0;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (bus.ack != 4'b0000) begin
            lat = n;
            ack_seen = bus.ack;
            break;
         end
      end
      bus.req[ch] = 1'b0;
   endtask

   task automatic read_acc(input int ch, output logic [32:0] v);
      bus.rd_sel = 2'(ch);
      step();
      v = bus.acc_out;
   endtask

   initial begin
      int          lat;
      logic [3:0]  ack_seen;
      logic [3:0]  exp_oh;
      logic [32:0] v;
      int          order [5];
      int          stamp [5];
      int          got;
      int          cyc;

      tbl[0] = '{0, 16'h0005, 33'h0_000A_0000, 4'b0000};
      tbl[1] = '{1, 16'h0010, 33'h0_0020_0000, 4'b0000};
      tbl[2] = '{2, 16'h0000, 33'h0_0000_0000, 4'b0000};
      tbl[3] = '{3, 16'h1234, 33'h0_2468_0000, 4'b0000};
      tbl[4] = '{0, 16'h0003, 33'h0_0010_0000, 4'b0000};
      tbl[5] = '{3, 16'hEDCC, 33'h0_0000_0000, 4'b1000};
      tbl[6] = '{2, 16'hFFFF, 33'h1_FFFE_0000, 4'b1000};
      tbl[7] = '{2, 16'h0002, 33'h0_0002_0000, 4'b1100};

      rst_n = 1'b0;
      bus.req = '0;
      bus.inc = '0;
      bus.clr = '0;
      bus.rd_sel = '0;
      #22;
      check("rst_ack", 64'(bus.ack), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_acc_out", 64'(bus.acc_out), 64'h0);
      check("rst_ovf", 64'(bus.ovf), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         read_acc(c, v);
         check($sformatf("rst_acc%0d", c), 64'(v), 64'h0);
      end

      // Single-channel adds, including zero increment and integer-field wrap.
      for (int i = 0; i < 8; i++) begin
         do_add(tbl[i].ch, tbl[i].inc, lat, ack_seen);
         exp_oh = 4'(1 << tbl[i].ch);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
         check($sformatf("vec%0d_ack", i), 64'(ack_seen), 64'(exp_oh));
         read_acc(tbl[i].ch, v);
         check($sformatf("vec%0d_acc", i), 64'(v), 64'(tbl[i].exp_acc));
         check($sformatf("vec%0d_ovf", i), 64'(bus.ovf), 64'(tbl[i].exp_ovf));
      end

      // Clear of ch1 on its own write-back edge, and of idle ch2 in parallel.
      bus.inc[16 +: 16] = 16'h0010;
      bus.req[1] = 1'b1;
      step();
      check("clr_busy_load", 64'(bus.busy), 64'h1);
      step();
      bus.clr = 4'b0110;
      step();
      bus.clr = '0;
      bus.req[1] = 1'b0;
      check("clr_ack", 64'(bus.ack), 64'b0010);
      check("clr_ovf", 64'(bus.ovf), 64'b1000);
      read_acc(1, v);
      check("clr_acc1", 64'(v), 64'h0);
      read_acc(2, v);
      check("clr_acc2", 64'(v), 64'h0);

      // Readback select held on ch1 across its write-back edge.
      bus.rd_sel = 2'd1;
      bus.inc[16 +: 16] = 16'h0007;
      bus.req[1] = 1'b1;
      step();
      step();
      check("rb_before", 64'(bus.acc_out), 64'h0);
      step();
      bus.req[1] = 1'b0;
      check("rb_ack", 64'(bus.ack), 64'b0010);
      check("rb_after", 64'(bus.acc_out), 64'h0_000E_0000);

      // Reset asserted while ch3 is in ADD.
      bus.inc[48 +: 16] = 16'h0005;
      bus.req[3] = 1'b1;
      step();
      step();
      check("rstop_busy_add", 64'(bus.busy), 64'h1);
      rst_n = 1'b0;
      #1;
      check("rstop_ack", 64'(bus.ack), 64'h0);
      check("rstop_busy", 64'(bus.busy), 64'h0);
      check("rstop_ovf", 64'(bus.ovf), 64'h0);
      bus.req[3] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      read_acc(3, v);
      check("rstop_acc3", 64'(v), 64'h0);

      // All four requesting with inc=1: fair order from channel 0, one ack per 3 cycles.
      bus.inc = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
      bus.req = 4'b1111;
      got = 0;
      cyc = 0;
      for (int n = 0; n < 40 && got < 5; n++) begin
         step();
         cyc++;
         if (bus.ack != 4'b0000) begin
            check($sformatf("rr_onehot%0d", got), 64'($countones(bus.ack)), 64'd1);
            order[got] = 0;
            for (int c = 0; c < 4; c++) begin
               if (bus.ack[c]) order[got] = c;
            end
            stamp[got] = cyc;
            got++;
            if (got == 5) bus.req = '0;
         end
      end
      bus.req = '0;
      check("rr_count", 64'(got), 64'd5);
      if (got == 5) begin
         check("rr_first_latency", 64'(stamp[0]), 64'd3);
         for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_order%0d", k), 64'(order[k]), 64'(k % 4));
         end
         for (int k = 1; k < 5; k++) begin
            check($sformatf("rr_gap%0d", k), 64'(stamp[k] - stamp[k-1]), 64'd3);
         end
      end
      read_acc(0, v);
      check("rr_acc0", 64'(v), 64'h0_0004_0000);
      for (int c = 1; c < 4; c++) begin
         read_acc(c, v);
         check($sformatf("rr_acc%0d", c), 64'(v), 64'h0_0002_0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
